// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and constants for the Booth multiplier controller
package booth_pkg;

    localparam int BOOTH_WIDTH = 6;

    // {Y0, Y-1} status codes that require an add/subtract before the shift
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_Y,
        ST_ITER,
        ST_SHIFT,
        ST_OUT_HI,
        ST_OUT_LO
    } booth_state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// rtl/booth_iter_counter.sv - loadable iteration down-counter with a count==1 flag
module booth_iter_counter
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CW'(WIDTH);
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign last = (r_count == CW'(1));

endmodule

// File: rtl/booth_controller.sv
// rtl/booth_controller.sv - radix-2 Booth multiplier control FSM
// BOOTH_OUT_HOLD_EN: adds outAck and holds each output word until it is accepted.
module booth_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = BOOTH_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] Y0Yminus1,
`ifdef BOOTH_OUT_HOLD_EN
    input  logic       outAck,
`endif
    output logic       ldX,
    output logic       ldY,
    output logic       ldA,
    output logic       initA,
    output logic       initYminusOne,
    output logic       aBarS,
    output logic       shRA,
    output logic       shRY,
    output logic       ldYminusOne,
    output logic       selL,
    output logic       selR,
    output logic       busy,
    output logic       done
);

    booth_state_t r_state;
    logic r_ldx;
    logic r_load_y;
    logic r_iter;
    logic r_shift;
    logic r_sel_l;
    logic r_sel_r;
    logic r_busy;

    logic w_ack;
    logic w_op_add;
    logic w_op_sub;
    logic w_addsub;
    logic w_shift_now;
    logic w_last;

`ifdef BOOTH_OUT_HOLD_EN
    assign w_ack = outAck;
`else
    assign w_ack = 1'b1;
`endif

    // ITER is Mealy on the datapath status: add/sub pairs load A, others shift now
    assign w_op_add    = r_iter && (Y0Yminus1 == ADD);
    assign w_op_sub    = r_iter && (Y0Yminus1 == SUB);
    assign w_addsub    = w_op_add || w_op_sub;
    assign w_shift_now = r_shift || (r_iter && !w_addsub);

    booth_iter_counter #(
        .WIDTH (WIDTH)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .load (r_load_y),
        .dec  (w_shift_now),
        .last (w_last)
    );

    // Moore flags are registered alongside the state so they mirror the state held next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_ldx    <= 1'b0;
            r_load_y <= 1'b0;
            r_iter   <= 1'b0;
            r_shift  <= 1'b0;
            r_sel_l  <= 1'b0;
            r_sel_r  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ldx    <= 1'b0;
            r_load_y <= 1'b0;
            r_iter   <= 1'b0;
            r_shift  <= 1'b0;
            r_sel_l  <= 1'b0;
            r_sel_r  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD_X;
                        r_ldx   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD_X: begin
                    r_state  <= ST_LOAD_Y;
                    r_load_y <= 1'b1;
                end
                ST_LOAD_Y: begin
                    r_state <= ST_ITER;
                    r_iter  <= 1'b1;
                end
                ST_ITER: begin
                    if (w_addsub) begin
                        r_state <= ST_SHIFT;
                        r_shift <= 1'b1;
                    end else if (w_last) begin
                        r_state <= ST_OUT_HI;
                        r_sel_l <= 1'b1;
                    end else begin
                        r_iter <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        r_state <= ST_OUT_HI;
                        r_sel_l <= 1'b1;
                    end else begin
                        r_state <= ST_ITER;
                        r_iter  <= 1'b1;
                    end
                end
                ST_OUT_HI: begin
                    if (w_ack) begin
                        r_state <= ST_OUT_LO;
                        r_sel_r <= 1'b1;
                    end else begin
                        r_sel_l <= 1'b1;
                    end
                end
                ST_OUT_LO: begin
                    if (w_ack) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sel_r <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ldX           = r_ldx;
    assign ldY           = r_load_y;
    assign initA         = r_load_y;
    assign initYminusOne = r_load_y;
    assign ldA           = w_addsub;
    assign aBarS         = w_op_sub;
    assign shRA          = w_shift_now;
    assign shRY          = w_shift_now;
    assign ldYminusOne   = w_shift_now;
    assign selL          = r_sel_l;
    assign selR          = r_sel_r;
    assign busy          = r_busy;
    assign done          = r_sel_r && w_ack;

endmodule

// File: tb/tb_booth_controller.sv
// tb/tb_booth_controller.sv - directed self-checking bench with a behavioural Booth datapath
module tb_booth_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] y0ym1;
`ifdef BOOTH_OUT_HOLD_EN
    logic       out_ack = 1'b0;
`endif
    logic ldX, ldY, ldA, initA, initYminusOne, aBarS, shRA, shRY, ldYminusOne;
    logic selL, selR, busy, done;

    logic [5:0] tb_x = '0;
    logic [5:0] tb_y = '0;
    logic [5:0] dp_x = '0;
    logic [5:0] dp_y = '0;
    logic [5:0] dp_a = '0;
    logic       dp_ym1 = 1'b0;
    logic [5:0] in_bus;
    logic [5:0] out_bus;
    logic [12:0] outs;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    booth_controller #(.WIDTH(6)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .Y0Yminus1     (y0ym1),
`ifdef BOOTH_OUT_HOLD_EN
        .outAck        (out_ack),
`endif
        .ldX           (ldX),
        .ldY           (ldY),
        .ldA           (ldA),
        .initA         (initA),
        .initYminusOne (initYminusOne),
        .aBarS         (aBarS),
        .shRA          (shRA),
        .shRY          (shRY),
        .ldYminusOne   (ldYminusOne),
        .selL          (selL),
        .selR          (selR),
        .busy          (busy),
        .done          (done)
    );

    // Behavioural 6-bit Booth datapath: {A,Y} shifts arithmetically, Y-1 captures Y0
    assign in_bus  = ldX ? tb_x : tb_y;
    assign y0ym1   = {dp_y[0], dp_ym1};
    assign out_bus = selL ? dp_a : (selR ? dp_y : 6'd0);
    assign outs    = {ldX, ldY, ldA, initA, initYminusOne, aBarS, shRA, shRY,
                      ldYminusOne, selL, selR, busy, done};

    always @(posedge clk) begin
        if (ldX) dp_x <= in_bus;
        if (ldY) dp_y <= in_bus;
        if (initA) dp_a <= '0;
        if (initYminusOne) dp_ym1 <= 1'b0;
        if (ldA) dp_a <= aBarS ? (dp_a - dp_x) : (dp_a + dp_x);
        if (shRA) dp_a <= {dp_a[5], dp_a[5:1]};
        if (shRY) dp_y <= {dp_a[0], dp_y[5:1]};
        if (ldYminusOne) dp_ym1 <= dp_y[0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_mult(input string tag, input logic [5:0] x, input logic [5:0] y,
                            input logic [5:0] exp_hi, input logic [5:0] exp_lo,
                            input int exp_done, input int exp_lda, input logic [3:0] exp_abs,
                            input bit hold_start, input int abort_at,
                            input int exp_l, input int exp_r);
        int c = 0;
        int nl = 0, nr = 0, nlda = 0, nsh = 0, nbusy = 0, ndone = 0;
        logic [5:0] hi = 'x;
        logic [5:0] lo = 'x;
        logic [3:0] abs_seq = '0;
        bit fin = 0;
        tb_x  = x;
        tb_y  = y;
        start = 1'b1;
        while (!fin && c < 80) begin
            @(negedge clk);
            c++;
            start = hold_start && (c != 5);
`ifdef BOOTH_OUT_HOLD_EN
            out_ack = (selL && nl == exp_l - 1) || (selR && nr == exp_r - 1);
`endif
            #1;
            if (abort_at == c) begin
                check({tag, "_in_shift"}, shRA, 1);
                rst = 1'b0;
                #1;
                check({tag, "_outs_zero"}, outs, 0);
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                #1;
                check({tag, "_idle_after"}, busy, 0);
                return;
            end
            if (selL) begin nl++; hi = out_bus; end
            if (selR) begin nr++; lo = out_bus; end
            if (ldA) begin nlda++; abs_seq = {abs_seq[2:0], aBarS}; end
            if (shRA) nsh++;
            if (busy) nbusy++;
            if (selL && selR) check({tag, "_sel_excl"}, {selL, selR}, 0);
            if (ldA && (shRA || shRY || ldYminusOne)) check({tag, "_lda_shift_excl"}, 1, 0);
            if (done) begin ndone++; fin = 1; end
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, fin ? c : -1, exp_done);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_lda_count"}, nlda, exp_lda);
        check({tag, "_absseq"}, abs_seq, exp_abs);
        check({tag, "_shifts"}, nsh, 6);
        check({tag, "_busy_cycles"}, nbusy, exp_done);
        check({tag, "_selL_cycles"}, nl, exp_l);
        check({tag, "_selR_cycles"}, nr, exp_r);
        check({tag, "_done_count"}, ndone, 1);
        @(negedge clk);
`ifdef BOOTH_OUT_HOLD_EN
        out_ack = 1'b0;
`endif
        #1;
        check({tag, "_post_busy"}, busy, 0);
        check({tag, "_post_done"}, done, 0);
        @(negedge clk);
        #1;
        check({tag, "_post2_busy"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_outs", outs, 0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        #1;
        check("idle_outs", outs, 0);

        run_mult("x3y5",   6'd3,  6'd5,  6'h00, 6'h0F, 14, 4, 4'b1010, 0, 0, 1, 1);
        run_mult("xm3y5",  6'h3D, 6'd5,  6'h3F, 6'h31, 14, 4, 4'b1010, 0, 0, 1, 1);
        run_mult("y0x21",  6'd21, 6'd0,  6'h00, 6'h00, 10, 0, 4'b0000, 0, 0, 1, 1);
        run_mult("ym1x7",  6'd7,  6'h3F, 6'h3F, 6'h39, 11, 1, 4'b0001, 0, 0, 1, 1);
        run_mult("hold_start", 6'd3, 6'd5, 6'h00, 6'h0F, 14, 4, 4'b1010, 1, 0, 1, 1);
        run_mult("abort",  6'd3,  6'd5,  6'h00, 6'h0F, 14, 4, 4'b1010, 0, 4, 1, 1);
        run_mult("after_abort", 6'd7, 6'h3F, 6'h3F, 6'h39, 11, 1, 4'b0001, 0, 0, 1, 1);
`ifdef BOOTH_OUT_HOLD_EN
        run_mult("ack_hold", 6'd3, 6'd5, 6'h00, 6'h0F, 19, 4, 4'b1010, 0, 0, 4, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/booth_controller.md
# booth_controller

Control unit for the 6-bit radix-2 Booth multiplier datapath. It sequences operand loading from the shared `inBus`, runs the Booth add/subtract/shift iterations from the `Y0Yminus1` status pair, and drives the product onto `outBus` high word then low word. It is the counterpart of the multiplier datapath: it drives every datapath control input and consumes the datapath's only status output.

## Interface
- `WIDTH`, default 6: operand width, which is also the iteration count.
- `clk` in 1: clock, rising-edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: request; sampled only in IDLE.
- `Y0Yminus1` in 2: {Y0, Y-1} status from the datapath.
- `outAck` in 1: consumer accepted the current output word. Present only with `BOOTH_OUT_HOLD_EN`.
- `ldX`, `ldY`, `ldA`, `initA`, `initYminusOne`, `aBarS`, `shRA`, `shRY`, `ldYminusOne`, `selL`, `selR` out 1 each: datapath controls.
- `busy` out 1: high from LOAD_X through OUT_LO inclusive.
- `done` out 1: single-cycle pulse, coincident with the last OUT_LO cycle.

## Operation
- States: IDLE, LOAD_X, LOAD_Y, ITER, SHIFT, OUT_HI, OUT_LO.
- IDLE: all outputs 0. `start`=1 moves to LOAD_X.
- LOAD_X: `ldX`=1. The source must hold X on `inBus`. Moves to LOAD_Y.
- LOAD_Y: `ldY`=1, `initA`=1, `initYminusOne`=1. The source must hold Y on `inBus`. The iteration counter loads `WIDTH`. Moves to ITER.
- ITER is Mealy on `Y0Yminus1`:
  - 01: `ldA`=1, `aBarS`=0 (A+X). Moves to SHIFT.
  - 10: `ldA`=1, `aBarS`=1 (A−X). Moves to SHIFT.
  - 00 or 11: the same outputs as SHIFT are asserted in this cycle, and the same transition rule applies.
- SHIFT: `shRA`=`shRY`=`ldYminusOne`=1 in the same cycle, so Y-1 captures Y0 before the shift. The counter decrements. If the counter was 1, moves to OUT_HI; otherwise moves to ITER.
- OUT_HI: `selL`=1 (A drives `outBus`).
- OUT_LO: `selR`=1 (Y drives `outBus`), `done`=1. Moves to IDLE.
- `selL` and `selR` are never high together.
- `ldA` and any shift enable are never high together.
- `start` while `busy` is ignored and not queued.
- Counter width is clog2(`WIDTH`+1). It never wraps, because exit happens on the decrement from 1.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): state IDLE, counter 0, every output 0.
- Reset mid-operation aborts immediately. The datapath contents are don't-care afterwards.
- Cycle 0 is the cycle `start` is sampled. LOAD_X is cycle 1 and LOAD_Y is cycle 2.
- The iteration phase takes `WIDTH` + k cycles, where k is the number of 01/10 pairs.
- OUT_HI and OUT_LO are one cycle each without the macro.
- Total latency from `start` to `done` is `WIDTH` + k + 4 cycles.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- `BOOTH_OUT_HOLD_EN` defined:
  - The `outAck` port exists.
  - OUT_HI holds `selL` until a cycle with `outAck`=1, then moves to OUT_LO.
  - OUT_LO holds `selR` until `outAck`=1. `done` pulses only in that accepting cycle, then the FSM moves to IDLE.
  - `busy` stays high throughout the hold.
- Undefined: no `outAck` port, and each output state lasts exactly one cycle.

## Structure
- Package `booth_pkg` holds:
  - the state enum;
  - the default `WIDTH`;
  - named constants for the `Y0Yminus1` codes (ADD=2'b01, SUB=2'b10).
- Sub-module `booth_iter_counter`: loadable down-counter with `load`, `dec`, and a `last` (count==1) flag.

## Test plan
Each scenario runs paired with the datapath, with X and Y driven on `inBus`.

- X=3, Y=5 → `busy` high cycles 1–14, `done` at cycle 14, `outBus`=000000 at cycle 13 and 001111 at cycle 14.
- X=−3, Y=5 → `outBus` 111111 then 110001; 4 `ldA` pulses, with `aBarS` sequence 1,0,1,0.
- Y=0, X=21 → zero `ldA` pulses, 6 shifts, `done` at cycle 10, product 0.
- Y=−1, X=7 → a single `ldA` with `aBarS`=1, `done` at cycle 11, product −7 (111111/111001).
- `start` held high throughout plus a second pulse mid-ITER → exactly one transaction. `rst` low during SHIFT → all outputs 0 within the same cycle, IDLE afterwards, and the next `start` completes correctly.
- `BOOTH_OUT_HOLD_EN`: `outAck` withheld 3 cycles in OUT_HI and 2 in OUT_LO → `selL` held 4 cycles, `selR` held 3 cycles, exactly one `done` pulse.
